// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one asynchronous single-port SRAM between the fetch
// port and the data port of the 16-bit pipeline. The data port has priority,
// and transactions are never preempted. All SRAM pins are registered.
// Optional store protection is compiled in with `define MEM_ARB_WPROT_EN.
module mem_arbiter #(
    parameter int unsigned SRAM_AW    = 18,
    parameter logic [15:0] PROT_LIMIT = 16'h4000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_i,
    input  logic [15:0]        if_addr_i,
    output logic [15:0]        if_inst_o,
    output logic               if_valid_o,
    input  logic               mem_req_i,
    input  logic               mem_we_i,
    input  logic [15:0]        mem_addr_i,
    input  logic [15:0]        mem_wdata_i,
    output logic [15:0]        mem_rdata_o,
    output logic               mem_done_o,
    output logic               stall_if_o,
    output logic               stall_mem_o,
    output logic               prot_err_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe_o,
    input  logic [15:0]        sram_dq_i
);

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        D_RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

`ifdef MEM_ARB_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic if_pend;
    logic mem_pend;
    logic prot_hit;
    logic prot_drop;

    // A port whose completion pulse is high this cycle is still holding its
    // old request; masking it here keeps it from being serviced twice.
    assign if_pend   = if_req_i & ~if_valid_o;
    assign mem_pend  = mem_req_i & ~mem_done_o;
    assign prot_hit  = WPROT & mem_we_i & (mem_addr_i < PROT_LIMIT);
    assign prot_drop = (state == IDLE) & mem_pend & mem_we_i & prot_hit;

    assign stall_if_o  = if_pend;
    assign stall_mem_o = mem_pend;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: arbitration in IDLE only, data port first
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_pend) begin
                    if (!mem_we_i)      state_nxt = D_RD;
                    else if (!prot_hit) state_nxt = WR_SETUP;
                end else if (if_pend) begin
                    state_nxt = IF_RD;
                end
            end
            IF_RD:    state_nxt = IDLE;
            D_RD:     state_nxt = IDLE;
            WR_SETUP: state_nxt = WR_PULSE;
            WR_PULSE: state_nxt = WR_HOLD;
            WR_HOLD:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // SRAM pins registered from the next state so strobes line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_dq_oe_o <= 1'b0;
            sram_addr_o  <= '0;
            sram_dq_o    <= '0;
        end else begin
            sram_ce_n_o  <= (state_nxt == IDLE);
            sram_oe_n_o  <= !((state_nxt == IF_RD) || (state_nxt == D_RD));
            sram_we_n_o  <= (state_nxt != WR_PULSE);
            sram_dq_oe_o <= (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                            (state_nxt == WR_HOLD);
            if ((state == IDLE) && (state_nxt == IF_RD))
                sram_addr_o <= SRAM_AW'(if_addr_i);
            if ((state == IDLE) && ((state_nxt == D_RD) || (state_nxt == WR_SETUP)))
                sram_addr_o <= SRAM_AW'(mem_addr_i);
            if ((state == IDLE) && (state_nxt == WR_SETUP))
                sram_dq_o <= mem_wdata_i;
        end
    end

    // Read capture on leaving a read state, completion pulses one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst_o   <= '0;
            mem_rdata_o <= '0;
            if_valid_o  <= 1'b0;
            mem_done_o  <= 1'b0;
        end else begin
            if_valid_o <= (state == IF_RD);
            mem_done_o <= (state == D_RD) || (state == WR_HOLD) || prot_drop;
            if (state == IF_RD) if_inst_o   <= sram_dq_i;
            if (state == D_RD)  mem_rdata_o <= sram_dq_i;
        end
    end

`ifdef MEM_ARB_WPROT_EN
    // Protection error pulses alongside the done of a dropped store
    always_ff @(posedge clk) begin
        if (rst) prot_err_o <= 1'b0;
        else     prot_err_o <= prot_drop;
    end
`else
    assign prot_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i;
    logic [15:0]   if_addr_i;
    logic [15:0]   if_inst_o;
    logic          if_valid_o;
    logic          mem_req_i;
    logic          mem_we_i;
    logic [15:0]   mem_addr_i;
    logic [15:0]   mem_wdata_i;
    logic [15:0]   mem_rdata_o;
    logic          mem_done_o;
    logic          stall_if_o;
    logic          stall_mem_o;
    logic          prot_err_o;
    logic [AW-1:0] sram_addr_o;
    logic          sram_ce_n_o;
    logic          sram_oe_n_o;
    logic          sram_we_n_o;
    logic [15:0]   sram_dq_o;
    logic          sram_dq_oe_o;
    logic [15:0]   sram_dq_i;

    always #5 clk = ~clk;

    mem_arbiter #(.SRAM_AW(AW), .PROT_LIMIT(16'h4000)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
        .if_valid_o(if_valid_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .prot_err_o(prot_err_o),
        .sram_addr_o(sram_addr_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o), .sram_dq_o(sram_dq_o), .sram_dq_oe_o(sram_dq_oe_o),
        .sram_dq_i(sram_dq_i)
    );

    // ---------------- external SRAM model ----------------
    logic [15:0] sram [0:65535];
    logic        preload = 1'b0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'h6A05;
        return a ^ 16'hC3A5;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 65536; i++) sram[i] <= init_val(16'(i));
        end else if (!sram_ce_n_o && !sram_we_n_o && sram_dq_oe_o) begin
            sram[sram_addr_o[15:0]] <= sram_dq_o;
        end
    end

    always_comb begin
        sram_dq_i = 16'h0000;
        if (!sram_ce_n_o && !sram_oe_n_o) sram_dq_i = sram[sram_addr_o[15:0]];
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic go_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic go_sample();
        @(negedge clk);
    endtask

    task automatic run_txn(input bit port, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, output int lat,
                           output logic [15:0] data, output logic prot);
        lat  = -1;
        data = '0;
        prot = 1'b0;
        if (port) begin
            mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        for (int k = 0; k <= 10; k++) begin
            go_sample();
            if (port ? mem_done_o : if_valid_o) begin
                lat  = k;
                data = port ? mem_rdata_o : if_inst_o;
                prot = prot_err_o;
                break;
            end
            go_drive();
        end
        go_drive();
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        go_sample();
        check("no_reissue_ce_n", 32'(sram_ce_n_o), 32'd1);
        go_drive();
    endtask

    typedef struct {
        string       name;
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        bit          prot;
    } vec_t;

    vec_t tbl [0:12];

    // reference model state for the random phase
    logic [15:0] ref_mem [0:15];
    int          free_at, if_due, mem_due, t_start, t_lat, t_kind;
    bit          mem_due_store, seen_if, seen_mem, exp_ifv, exp_md, active;
    logic [15:0] t_addr, t_wdata, exp_if_data, exp_mem_data;

    initial begin
        int          lat;
        logic [15:0] data;
        logic        prot;
        int          pulses;
        int          ph;

        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;

        tbl[0]  = '{"fetch_0010",  1'b0, 1'b0, 16'h0010, 16'h0000, 16'h6A05, 2, 1'b0};
        tbl[1]  = '{"store_8000",  1'b1, 1'b1, 16'h8000, 16'hBEEF, 16'h0000, 4, 1'b0};
        tbl[2]  = '{"load_8000",   1'b1, 1'b0, 16'h8000, 16'h0000, 16'hBEEF, 2, 1'b0};
        tbl[3]  = '{"fetch_8000",  1'b0, 1'b0, 16'h8000, 16'h0000, 16'hBEEF, 2, 1'b0};
        tbl[4]  = '{"load_0000",   1'b1, 1'b0, 16'h0000, 16'h0000, 16'hC3A5, 2, 1'b0};
        tbl[5]  = '{"store_ffff",  1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 4, 1'b0};
        tbl[6]  = '{"load_ffff",   1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 2, 1'b0};
        tbl[7]  = '{"store_4000",  1'b1, 1'b1, 16'h4000, 16'h5555, 16'h0000, 4, 1'b0};
        tbl[8]  = '{"load_4000",   1'b1, 1'b0, 16'h4000, 16'h0000, 16'h5555, 2, 1'b0};
`ifdef MEM_ARB_WPROT_EN
        tbl[9]  = '{"store_3fff",  1'b1, 1'b1, 16'h3FFF, 16'h7777, 16'h0000, 1, 1'b1};
        tbl[10] = '{"load_3fff",   1'b1, 1'b0, 16'h3FFF, 16'h0000, 16'hFC5A, 2, 1'b0};
        tbl[11] = '{"store_0100",  1'b1, 1'b1, 16'h0100, 16'hAAAA, 16'h0000, 1, 1'b1};
        tbl[12] = '{"load_0100",   1'b1, 1'b0, 16'h0100, 16'h0000, 16'hC2A5, 2, 1'b0};
`else
        tbl[9]  = '{"store_3fff",  1'b1, 1'b1, 16'h3FFF, 16'h7777, 16'h0000, 4, 1'b0};
        tbl[10] = '{"load_3fff",   1'b1, 1'b0, 16'h3FFF, 16'h0000, 16'h7777, 2, 1'b0};
        tbl[11] = '{"store_0100",  1'b1, 1'b1, 16'h0100, 16'hAAAA, 16'h0000, 4, 1'b0};
        tbl[12] = '{"load_0100",   1'b1, 1'b0, 16'h0100, 16'h0000, 16'hAAAA, 2, 1'b0};
`endif

        // reset with SRAM preload
        go_drive();
        preload = 1'b1;
        go_drive();
        preload = 1'b0;
        go_drive();
        go_sample();
        check("rst_ce_n",   32'(sram_ce_n_o),  32'd1);
        check("rst_oe_n",   32'(sram_oe_n_o),  32'd1);
        check("rst_we_n",   32'(sram_we_n_o),  32'd1);
        check("rst_dq_oe",  32'(sram_dq_oe_o), 32'd0);
        check("rst_addr",   32'(sram_addr_o),  32'd0);
        check("rst_dq",     32'(sram_dq_o),    32'd0);
        check("rst_inst",   32'(if_inst_o),    32'd0);
        check("rst_rdata",  32'(mem_rdata_o),  32'd0);
        check("rst_valid",  32'(if_valid_o),   32'd0);
        check("rst_done",   32'(mem_done_o),   32'd0);
        check("rst_prot",   32'(prot_err_o),   32'd0);
        go_drive();
        rst = 1'b0;
        go_drive();

        // fetch with detailed timing
        if_req_i = 1'b1; if_addr_i = 16'h0010;
        go_sample();
        check("f_stall_n", 32'(stall_if_o), 32'd1);
        go_drive(); go_sample();
        check("f_oe_n1",   32'(sram_oe_n_o), 32'd0);
        check("f_addr1",   32'(sram_addr_o), 32'h00010);
        check("f_stall_n1", 32'(stall_if_o), 32'd1);
        go_drive(); go_sample();
        check("f_valid2",  32'(if_valid_o), 32'd1);
        check("f_inst2",   32'(if_inst_o),  32'h6A05);
        check("f_stall_n2", 32'(stall_if_o), 32'd0);
        go_drive();
        if_req_i = 1'b0;
        go_sample();
        check("f_no_second_read", 32'(sram_oe_n_o), 32'd1);
        go_drive();

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, data, prot);
            check({tbl[i].name, "_lat"}, 32'(lat), 32'(tbl[i].lat));
            check({tbl[i].name, "_prot"}, 32'(prot), 32'(tbl[i].prot));
            if (!tbl[i].we) check({tbl[i].name, "_data"}, 32'(data), 32'(tbl[i].rdata));
        end

        // store strobe sequence
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'hA000; mem_wdata_i = 16'h1357;
        go_drive(); go_sample();
        check("st_we_n1",  32'(sram_we_n_o),  32'd1);
        check("st_dqoe1",  32'(sram_dq_oe_o), 32'd1);
        check("st_ce_n1",  32'(sram_ce_n_o),  32'd0);
        check("st_oe_n1",  32'(sram_oe_n_o),  32'd1);
        check("st_addr1",  32'(sram_addr_o),  32'h0A000);
        check("st_dq1",    32'(sram_dq_o),    32'h1357);
        go_drive(); go_sample();
        check("st_we_n2",  32'(sram_we_n_o),  32'd0);
        check("st_dqoe2",  32'(sram_dq_oe_o), 32'd1);
        go_drive(); go_sample();
        check("st_we_n3",  32'(sram_we_n_o),  32'd1);
        check("st_dqoe3",  32'(sram_dq_oe_o), 32'd1);
        check("st_done3",  32'(mem_done_o),   32'd0);
        go_drive(); go_sample();
        check("st_done4",  32'(mem_done_o),   32'd1);
        check("st_dqoe4",  32'(sram_dq_oe_o), 32'd0);
        check("st_stall4", 32'(stall_mem_o),  32'd0);
        go_drive();
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        go_drive();
        run_txn(1'b1, 1'b0, 16'hA000, 16'h0000, lat, data, prot);
        check("st_readback", 32'(data), 32'h1357);

        // contention: both ports in the same IDLE cycle, mem load wins
        if_req_i = 1'b1; if_addr_i = 16'h0010;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 16'h8000;
        go_sample();
        check("c_stall_if0", 32'(stall_if_o), 32'd1);
        go_drive(); go_sample();
        check("c_oe_n1",     32'(sram_oe_n_o), 32'd0);
        check("c_addr1",     32'(sram_addr_o), 32'h08000);
        check("c_stall_if1", 32'(stall_if_o),  32'd1);
        go_drive(); go_sample();
        check("c_done2",     32'(mem_done_o),  32'd1);
        check("c_rdata2",    32'(mem_rdata_o), 32'hBEEF);
        check("c_stall_if2", 32'(stall_if_o),  32'd1);
        check("c_stall_mem2", 32'(stall_mem_o), 32'd0);
        go_drive();
        mem_req_i = 1'b0;
        go_sample();
        check("c_oe_n3",     32'(sram_oe_n_o), 32'd0);
        check("c_addr3",     32'(sram_addr_o), 32'h00010);
        check("c_stall_if3", 32'(stall_if_o),  32'd1);
        go_drive(); go_sample();
        check("c_valid4",    32'(if_valid_o),  32'd1);
        check("c_inst4",     32'(if_inst_o),   32'h6A05);
        check("c_stall_if4", 32'(stall_if_o),  32'd0);
        go_drive();
        if_req_i = 1'b0;
        go_drive();

        // data request arriving during a fetch
        if_req_i = 1'b1; if_addr_i = 16'h0010;
        go_drive();
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 16'hFFFF;
        go_sample();
        check("m_addr1",      32'(sram_addr_o), 32'h00010);
        check("m_stall_mem1", 32'(stall_mem_o), 32'd1);
        go_drive(); go_sample();
        check("m_valid2", 32'(if_valid_o), 32'd1);
        check("m_inst2",  32'(if_inst_o),  32'h6A05);
        check("m_done2",  32'(mem_done_o), 32'd0);
        go_drive();
        if_req_i = 1'b0;
        go_sample();
        check("m_oe_n3",  32'(sram_oe_n_o), 32'd0);
        check("m_addr3",  32'(sram_addr_o), 32'h0FFFF);
        go_drive(); go_sample();
        check("m_done4",  32'(mem_done_o),  32'd1);
        check("m_rdata4", 32'(mem_rdata_o), 32'h1234);
        go_drive();
        mem_req_i = 1'b0;
        go_drive();

        // reset during WR_PULSE
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'hA001; mem_wdata_i = 16'h2468;
        go_drive();
        go_drive();
        rst = 1'b1;
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        go_sample();
        check("r_we_n_pulse", 32'(sram_we_n_o), 32'd0);
        go_drive();
        rst = 1'b0;
        go_sample();
        check("r_we_n",  32'(sram_we_n_o),  32'd1);
        check("r_dq_oe", 32'(sram_dq_oe_o), 32'd0);
        check("r_ce_n",  32'(sram_ce_n_o),  32'd1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_done_o) pulses++;
            go_drive(); go_sample();
        end
        check("r_no_done", 32'(pulses), 32'd0);

        // randomized phase against a transaction-level reference model
        go_drive();
        rst = 1'b1;
        go_drive();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(16'h9000 | 16'(i));
        free_at = 0; if_due = -1; mem_due = -1; t_start = -100; t_lat = 0; t_kind = 0;
        mem_due_store = 1'b0; seen_if = 1'b0; seen_mem = 1'b0;
        t_addr = '0; t_wdata = '0; exp_if_data = '0; exp_mem_data = '0;

        for (int c = 0; c < 600; c++) begin
            if (if_req_i && seen_if) if_req_i = 1'b0;
            if (!if_req_i && ($urandom_range(2) == 0)) begin
                if_req_i  = 1'b1;
                if_addr_i = 16'h9000 | 16'($urandom_range(15));
            end
            if (mem_req_i && seen_mem) begin
                mem_req_i = 1'b0; mem_we_i = 1'b0;
            end
            if (!mem_req_i && ($urandom_range(2) == 0)) begin
                mem_req_i   = 1'b1;
                mem_we_i    = 1'($urandom_range(1));
                mem_addr_i  = 16'h9000 | 16'($urandom_range(15));
                mem_wdata_i = 16'($urandom);
            end
            go_sample();

            exp_ifv = (if_due == c);
            exp_md  = (mem_due == c);
            check("rnd_if_valid", 32'(if_valid_o), 32'(exp_ifv));
            check("rnd_mem_done", 32'(mem_done_o), 32'(exp_md));
            if (exp_ifv) check("rnd_if_inst", 32'(if_inst_o), 32'(exp_if_data));
            if (exp_md && !mem_due_store) check("rnd_rdata", 32'(mem_rdata_o), 32'(exp_mem_data));
            check("rnd_stall_if",  32'(stall_if_o),  32'(if_req_i & ~exp_ifv));
            check("rnd_stall_mem", 32'(stall_mem_o), 32'(mem_req_i & ~exp_md));
            check("rnd_prot",      32'(prot_err_o),  32'd0);

            active = (c > t_start) && (c < t_start + t_lat);
            ph     = c - t_start;
            check("rnd_ce_n",  32'(sram_ce_n_o),  32'(!active));
            check("rnd_oe_n",  32'(sram_oe_n_o),  32'(!(active && t_kind != 2)));
            check("rnd_we_n",  32'(sram_we_n_o),  32'(!(active && t_kind == 2 && ph == 2)));
            check("rnd_dq_oe", 32'(sram_dq_oe_o), 32'(active && t_kind == 2));
            if (active) check("rnd_addr", 32'(sram_addr_o), 32'(t_addr));
            if (active && t_kind == 2) check("rnd_dq", 32'(sram_dq_o), 32'(t_wdata));

            if (c >= free_at) begin
                if (mem_req_i && !exp_md) begin
                    t_start = c;
                    t_addr  = mem_addr_i;
                    t_wdata = mem_wdata_i;
                    t_kind  = mem_we_i ? 2 : 1;
                    t_lat   = mem_we_i ? 4 : 2;
                    mem_due = c + t_lat;
                    mem_due_store = mem_we_i;
                    if (mem_we_i) ref_mem[mem_addr_i[3:0]] = mem_wdata_i;
                    else          exp_mem_data = ref_mem[mem_addr_i[3:0]];
                    free_at = c + t_lat;
                end else if (if_req_i && !exp_ifv) begin
                    t_start = c;
                    t_addr  = if_addr_i;
                    t_kind  = 0;
                    t_lat   = 2;
                    if_due  = c + 2;
                    exp_if_data = ref_mem[if_addr_i[3:0]];
                    free_at = c + 2;
                end
            end

            seen_if  = if_valid_o;
            seen_mem = mem_done_o;
            go_drive();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
